// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bundle for the deserializer.
// The slave modport is the receiver; the master side drives the line and observes the word.
interface deserializer_if #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 8
);
    logic              serial_data;
    logic [DATA_W-1:0] parallel_data;
    logic              data_valid;
    logic              busy;
    logic              sync_lost;
    logic [CNT_W-1:0]  frame_cnt;

    modport master (
        output serial_data,
        input  parallel_data, data_valid, busy, sync_lost, frame_cnt
    );

    modport slave (
        input  serial_data,
        output parallel_data, data_valid, busy, sync_lost, frame_cnt
    );
endinterface

// File: rtl/deserializer.sv
// Serial frame receiver: start field of START_LEN zeros, DATA_W bits LSB first,
// one-cycle valid strobe per word, back-to-back tracking and sync-loss flag.
module deserializer #(
    parameter int DATA_W    = 12,
    parameter int START_LEN = 1,
    parameter int CNT_W     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    deserializer_if.slave bus
);
    localparam int BC_W = $clog2(DATA_W + 1);
    localparam int ZC_W = $clog2(START_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_HUNT} state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [DATA_W-1:0] r_pdata, w_pdata_nxt;
    logic [BC_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [ZC_W-1:0]   r_zcnt, w_zcnt_nxt;
    logic [CNT_W-1:0]  r_frame_cnt, w_frame_cnt_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_sync_lost, w_sync_lost_nxt;
    logic              r_busy, w_busy_nxt;
    logic [DATA_W-1:0] w_shift_in;

    assign w_shift_in = {bus.serial_data, r_shift[DATA_W-1:1]};
    assign w_busy_nxt = (w_state_nxt == S_START) || (w_state_nxt == S_DATA);

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_pdata_nxt     = r_pdata;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_zcnt_nxt      = r_zcnt;
        w_frame_cnt_nxt = r_frame_cnt;
        w_valid_nxt     = 1'b0;
        w_sync_lost_nxt = 1'b0;
        unique case (r_state)
            S_IDLE, S_HUNT: begin
                if (!bus.serial_data) begin
                    w_bit_cnt_nxt = '0;
                    if (START_LEN == 1) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_START;
                        w_zcnt_nxt  = ZC_W'(1);
                    end
                end else if (r_state == S_HUNT) begin
                    // A frame just ended and no new start field followed it
                    w_state_nxt     = S_IDLE;
                    w_sync_lost_nxt = 1'b1;
                end
            end
            S_START: begin
                if (bus.serial_data) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_zcnt_nxt = r_zcnt + 1'b1;
                    if (r_zcnt == ZC_W'(START_LEN - 1)) begin
                        w_state_nxt   = S_DATA;
                        w_bit_cnt_nxt = '0;
                    end
                end
            end
            S_DATA: begin
                w_shift_nxt   = w_shift_in;
                w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                if (r_bit_cnt == BC_W'(DATA_W - 1)) begin
                    w_pdata_nxt     = w_shift_in;
                    w_valid_nxt     = 1'b1;
                    w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                    w_state_nxt     = S_HUNT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_pdata     <= '0;
            r_bit_cnt   <= '0;
            r_zcnt      <= '0;
            r_frame_cnt <= '0;
            r_valid     <= 1'b0;
            r_sync_lost <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_pdata     <= w_pdata_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_zcnt      <= w_zcnt_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_valid     <= w_valid_nxt;
            r_sync_lost <= w_sync_lost_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.parallel_data = r_pdata;
    assign bus.data_valid    = r_valid;
    assign bus.busy          = r_busy;
    assign bus.sync_lost     = r_sync_lost;
    assign bus.frame_cnt     = r_frame_cnt;
endmodule
